// File: rtl/yd_pkg.sv
// Shared defaults and types for the yd writeback arbiter.
// Holds the default widths, the writeback request record, and a helper
// that sizes the round-robin pointer for a given requester count.
package yd_pkg;

    localparam int YD_DW   = 16;
    localparam int YD_AW   = 4;
    localparam int YD_NREQ = 3;

    // One writeback request as seen by the arbiter.
    typedef struct packed {
        logic              valid;
        logic [YD_AW-1:0]  addr;
        logic [YD_DW-1:0]  data;
    } wb_req_t;

    // Width of an index into NREQ requesters (never below one bit).
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/yd_rr_pick.sv
// Rotating find-first-two picker.
// Scans the valid vector starting at ptr and wrapping past NREQ-1. The first
// valid entry wins grant0; the next valid entry whose address does not match
// the grant0 winner wins grant1. conflict[i][j] is 1 when requesters i and j
// target the same address.
module yd_rr_pick
    import yd_pkg::*;
#(
    parameter  int NREQ = YD_NREQ,
    localparam int PW   = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0]            valid,
    input  logic [PW-1:0]              ptr,
    input  logic [NREQ-1:0][NREQ-1:0]  conflict,
    output logic [NREQ-1:0]            grant0,
    output logic [NREQ-1:0]            grant1
);

    // Walk the requesters in rotation order and pick up to two winners.
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        logic [PW-1:0] sel0;
        logic          found0;
        logic          found1;
        grant0 = '0;
        grant1 = '0;
        sum    = '0;
        idx    = '0;
        sel0   = '0;
        found0 = 1'b0;
        found1 = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            // ptr + k stays below 2*NREQ, so one conditional subtract wraps it.
            sum = {1'b0, ptr} + (PW+1)'(k);
            idx = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ)) : sum[PW-1:0];
            if (valid[idx]) begin
                if (!found0) begin
                    grant0[idx] = 1'b1;
                    sel0        = idx;
                    found0      = 1'b1;
                end else if (!found1 && !conflict[sel0][idx]) begin
                    grant1[idx] = 1'b1;
                    found1      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/yd_wb_arb.sv
// Two-port register-file writeback arbiter.
// Grants up to two of NREQ writeback requesters per cycle in round-robin
// order, refusing a second grant to the same destination register, and
// registers the winners onto write ports 0 and 1 with one cycle of latency.
// Optional feature: define YD_WB_FWD_EN to add read forwarding from the
// registered write ports onto two register-file read ports.
module yd_wb_arb
    import yd_pkg::*;
#(
    parameter int DW   = YD_DW,
    parameter int AW   = YD_AW,
    parameter int NREQ = YD_NREQ
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               we0,
    output logic [AW-1:0]      waddr0,
    output logic [DW-1:0]      din0,
    output logic               we1,
    output logic [AW-1:0]      waddr1,
    output logic [DW-1:0]      din1
`ifdef YD_WB_FWD_EN
    ,
    input  logic [AW-1:0]      raddr0,
    input  logic [AW-1:0]      raddr1,
    input  logic [DW-1:0]      rf_dout0,
    input  logic [DW-1:0]      rf_dout1,
    output logic [DW-1:0]      rdata0,
    output logic [DW-1:0]      rdata1
`endif
);

    localparam int PW = ptr_width(NREQ);

    logic [PW-1:0]             rr_ptr_reg;
    logic [PW-1:0]             rr_ptr_next;
    logic [NREQ-1:0]           eligible;
    logic [NREQ-1:0][NREQ-1:0] conflict;
    logic [NREQ-1:0]           grant0;
    logic [NREQ-1:0]           grant1;
    logic                      any0;
    logic                      any1;
    logic [AW-1:0]             addr0_sel;
    logic [DW-1:0]             data0_sel;
    logic [AW-1:0]             addr1_sel;
    logic [DW-1:0]             data1_sel;
    logic [PW-1:0]             last_idx;

    // A stalled pipeline takes nothing, so hide every request from the picker.
    assign eligible = hold ? '0 : req_valid;

    // Pairwise destination comparison feeding the picker's conflict check.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_conf_row
        for (genvar gj = 0; gj < NREQ; gj++) begin : g_conf_col
            assign conflict[gi][gj] = (req_addr[gi*AW +: AW] == req_addr[gj*AW +: AW]);
        end
    end

    yd_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .valid    (eligible),
        .ptr      (rr_ptr_reg),
        .conflict (conflict),
        .grant0   (grant0),
        .grant1   (grant1)
    );

    // Grants are the handshake; nothing is offered while reset is asserted.
    assign req_ready = rst ? (grant0 | grant1) : '0;
    assign any0      = |grant0;
    assign any1      = |grant1;

    // Steer the winners' address/data to each port and find the last winner.
    always_comb begin
        addr0_sel = '0;
        data0_sel = '0;
        addr1_sel = '0;
        data1_sel = '0;
        last_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant0[i]) begin
                addr0_sel = req_addr[i*AW +: AW];
                data0_sel = req_data[i*DW +: DW];
                last_idx  = PW'(i);
            end
        end
        // Port 1 always lies later in the scan, so it overrides last_idx.
        for (int i = 0; i < NREQ; i++) begin
            if (grant1[i]) begin
                addr1_sel = req_addr[i*AW +: AW];
                data1_sel = req_data[i*DW +: DW];
                last_idx  = PW'(i);
            end
        end
    end

    // Pointer moves just past the last requester served; idle cycles keep it.
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (any0) begin
            rr_ptr_next = (last_idx == PW'(NREQ-1)) ? '0 : last_idx + PW'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    // Write port registers: strobe every cycle, address/data only when granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we0    <= 1'b0;
            waddr0 <= '0;
            din0   <= '0;
            we1    <= 1'b0;
            waddr1 <= '0;
            din1   <= '0;
        end else begin
            we0 <= any0;
            we1 <= any1;
            if (any0) begin
                waddr0 <= addr0_sel;
                din0   <= data0_sel;
            end
            if (any1) begin
                waddr1 <= addr1_sel;
                din1   <= data1_sel;
            end
        end
    end

`ifdef YD_WB_FWD_EN
    // Bypass a write landing this cycle onto a read of the same register;
    // the two write ports never share an address, so priority is irrelevant.
    assign rdata0 = (we0 && (waddr0 == raddr0)) ? din0 :
                    (we1 && (waddr1 == raddr0)) ? din1 : rf_dout0;
    assign rdata1 = (we0 && (waddr0 == raddr1)) ? din0 :
                    (we1 && (waddr1 == raddr1)) ? din1 : rf_dout1;
`endif

endmodule

// File: doc/yd_wb_arb.md
YD_WB_ARB -- requirements
Module: yd_wb_arb

Interface
REQ-001 Parameter DW, default 16, data width of a register-file write.
REQ-002 Parameter AW, default 4, register address width.
REQ-003 Parameter NREQ, default 3, number of writeback requesters (range 2..8).
REQ-004 Port list SHALL be as follows (one clock; reset is asynchronous and active-low):
  clk  input  1  rising-edge clock
  rst  input  1  asynchronous reset, active-low
  hold  input  1  pipeline stall; suppresses all grants
  req_valid  input  NREQ  per-requester write request
  req_addr  input  NREQ*AW  per-requester destination, requester i at [i*AW +: AW]
  req_data  input  NREQ*DW  per-requester write data, requester i at [i*DW +: DW]
  req_ready  output  NREQ  per-requester grant; a write transfers when valid&ready
  we0, waddr0[AW], din0[DW]  output  -  register-file write port 0, registered
  we1, waddr1[AW], din1[DW]  output  -  register-file write port 1, registered

Function
REQ-005 req_ready SHALL be combinational from req_valid, req_addr, hold and the round-robin pointer, and SHALL be 0 for any requester whose req_valid is 0.
REQ-006 Each cycle, the block SHALL scan requesters in rotating order, starting at rr_ptr: first valid -> port 0, next valid with addr != port-0 addr -> port 1.
REQ-007 A valid requester whose addr equals the port-0 addr in the same cycle SHALL NOT be granted; it SHALL stay pending with its inputs held.
REQ-008 At most two grants per cycle; at most one grant per requester per cycle.
REQ-009 Granted writes SHALL appear on we/waddr/din exactly one cycle after the handshake (1-cycle latency); ungranted ports SHALL drive we=0 that cycle, and waddr/din SHALL hold their previous values.
REQ-010 rr_ptr SHALL advance to (last granted index + 1) mod NREQ after any cycle with at least one grant, and SHALL be unchanged otherwise.
REQ-011 hold=1 SHALL force req_ready=0, freeze rr_ptr and give we0=we1=0 on the next cycle; writes already registered SHALL still issue.
REQ-012 Wrap-around: the scan order SHALL be rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ..., rr_ptr-1.
REQ-013 A requester that drops req_valid without a handshake SHALL NOT be granted, and no state SHALL be kept for it.

Reset
REQ-014 On rst=0, asynchronously: we0=we1=0, waddr0=waddr1=0, din0=din1=0, rr_ptr=0, forwarding registers=0.
REQ-015 Reset during an in-flight grant SHALL drop that write; it SHALL NOT reach the register file.
REQ-016 req_ready SHALL be 0 while rst=0.

Configuration
REQ-017 Macro YD_WB_FWD_EN SHALL compile in read forwarding.
REQ-018 With YD_WB_FWD_EN, extra ports SHALL exist: raddr0/raddr1 input AW, rf_dout0/rf_dout1 input DW, rdata0/rdata1 output DW.
REQ-019 With YD_WB_FWD_EN, rdataN SHALL be combinational: if weK=1 and waddrK==raddrN, then dinK; otherwise rf_doutN. Port-0/port-1 match is exclusive per REQ-007.
REQ-020 Without YD_WB_FWD_EN, these ports and this logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-021 Package yd_pkg SHALL hold the DW/AW/NREQ defaults and typedef wb_req_t {valid, addr, data}.
REQ-022 The rotating find-first-two logic SHALL be sub-module yd_rr_pick (inputs: valid vector, pointer, address-conflict vector; outputs: two one-hot grants).

Verification
REQ-023 Reset, then valid=3'b111, addr={3,2,1}, data={A3,A2,A1}, rr_ptr=0 -> ready=3'b011; next cycle we0=1/waddr0=1/din0=A1 and we1=1/waddr1=2/din1=A2; rr_ptr=2.
REQ-024 Same-address conflict: req0 and req1 both addr 5, req2 invalid -> only req0 granted; req1 granted the next cycle on port 0 with we1=0.
REQ-025 Wrap-around: rr_ptr=2, all valid, distinct addresses -> req2 to port 0 and req0 to port 1; rr_ptr becomes 1.
REQ-026 hold=1 for 2 cycles with all valid -> ready=0 and we0=we1=0 from the next cycle on; rr_ptr unchanged; after hold=0, normal grants resume.
REQ-027 rst pulsed low while a granted write is in flight -> we0=we1=0 immediately, with no write issued.
REQ-028 YD_WB_FWD_EN: waddr0=F, din0=1FFF, we0=1, raddr1=F, rf_dout1=0 -> rdata1=1FFF; next cycle with we0=0 -> rdata1=rf_dout1.
